// File: rtl/nic_mesh_fifo_if.sv
// nic_mesh_fifo_if: processor register port and router channel bundled for the mesh NIC.
interface nic_mesh_fifo_if #(parameter int DATA_W = 64);
  logic [1:0]        addr;
  logic [DATA_W-1:0] d_in;
  logic [DATA_W-1:0] d_out;
  logic              nicEn;
  logic              nicEnWr;
  logic              net_si;
  logic              net_ri;
  logic [DATA_W-1:0] net_di;
  logic              net_so;
  logic              net_ro;
  logic [DATA_W-1:0] net_do;
  logic              net_polarity;
  modport master (output addr, d_in, nicEn, nicEnWr, net_si, net_di, net_ro, net_polarity,
                  input d_out, net_ri, net_so, net_do);
  modport slave  (input addr, d_in, nicEn, nicEnWr, net_si, net_di, net_ro, net_polarity,
                  output d_out, net_ri, net_so, net_do);
endinterface

// File: rtl/nic_mesh_fifo.sv
// nic_mesh_fifo: mesh NIC with input/output FIFOs, occupancy status and sticky write-drop flag.
module nic_mesh_fifo #(
  parameter int DATA_W    = 64,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  nic_mesh_fifo_if.slave   bus
);
  localparam int IAW    = $clog2(IN_DEPTH);
  localparam int OAW    = $clog2(OUT_DEPTH);
  localparam int ICNT_W = IAW + 1;
  localparam int OCNT_W = OAW + 1;

  function automatic logic [DATA_W-1:0] rev(input logic [DATA_W-1:0] x);
    for (int i = 0; i < DATA_W; i++) rev[i] = x[DATA_W-1-i];
  endfunction

  logic [DATA_W-1:0] in_mem  [IN_DEPTH];
  logic [DATA_W-1:0] out_mem [OUT_DEPTH];
  logic [IAW-1:0]    in_wp_q, in_wp_d, in_rp_q, in_rp_d;
  logic [OAW-1:0]    out_wp_q, out_wp_d, out_rp_q, out_rp_d;
  logic [ICNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [OCNT_W-1:0] out_cnt_q, out_cnt_d;
  logic              drop_q, drop_d;
  logic              rd, wr_out, in_ne, out_ne, in_full, out_full;
  logic              in_push, in_pop, out_push, out_pop;
  logic [DATA_W-1:0] in_head, out_head, out_rev, in_stat, out_stat;

  always_comb begin
    rd       = bus.nicEn & ~bus.nicEnWr;
    wr_out   = bus.nicEn & bus.nicEnWr & (bus.addr == 2'b10);
    in_ne    = in_cnt_q != '0;
    out_ne   = out_cnt_q != '0;
    in_full  = in_cnt_q == ICNT_W'(IN_DEPTH);
    out_full = out_cnt_q == OCNT_W'(OUT_DEPTH);
    bus.net_ri = ~in_full & ~reset;
    out_pop    = bus.net_ro & out_ne & ~reset;
    bus.net_so = out_pop;
    in_push  = bus.net_si & bus.net_ri;
    in_pop   = rd & (bus.addr == 2'b00) & in_ne;
    // a full output FIFO still accepts a write when its head leaves this same cycle
    out_push = wr_out & (~out_full | out_pop);
    in_head  = in_ne ? in_mem[in_rp_q] : '0;
    out_head = out_ne ? out_mem[out_rp_q] : '0;
    out_rev  = rev(out_head);
    bus.net_do = out_pop ? {out_rev[DATA_W-1:1], ~bus.net_polarity} : out_rev;
    in_stat  = '0;
    in_stat[0] = in_ne;
    in_stat[ICNT_W:1] = in_cnt_q;
    out_stat = '0;
    out_stat[0] = out_full;
    out_stat[OCNT_W:1] = out_cnt_q;
    out_stat[DATA_W-1] = drop_q;
    bus.d_out = (rd && bus.addr == 2'b01) ? in_stat :
                (rd && bus.addr == 2'b10) ? out_head :
                (rd && bus.addr == 2'b11) ? out_stat : in_head;
    drop_d    = (wr_out & out_full & ~out_pop) | (drop_q & ~(rd & (bus.addr == 2'b11)));
    in_wp_d   = in_wp_q + IAW'(in_push);
    in_rp_d   = in_rp_q + IAW'(in_pop);
    in_cnt_d  = in_cnt_q + ICNT_W'(in_push) - ICNT_W'(in_pop);
    out_wp_d  = out_wp_q + OAW'(out_push);
    out_rp_d  = out_rp_q + OAW'(out_pop);
    out_cnt_d = out_cnt_q + OCNT_W'(out_push) - OCNT_W'(out_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_wp_q   <= '0;
      in_rp_q   <= '0;
      in_cnt_q  <= '0;
      out_wp_q  <= '0;
      out_rp_q  <= '0;
      out_cnt_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      in_wp_q   <= in_wp_d;
      in_rp_q   <= in_rp_d;
      in_cnt_q  <= in_cnt_d;
      out_wp_q  <= out_wp_d;
      out_rp_q  <= out_rp_d;
      out_cnt_q <= out_cnt_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wp_q] <= rev(bus.net_di);
    if (out_push) out_mem[out_wp_q] <= bus.d_in;
  end
endmodule

// File: tb/tb_nic_mesh_fifo.sv
// tb_nic_mesh_fifo: directed vectors with hand-computed expectations for nic_mesh_fifo.
module tb_nic_mesh_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;

  nic_mesh_fifo_if #(.DATA_W(64)) bus ();
  nic_mesh_fifo #(.DATA_W(64), .IN_DEPTH(4), .OUT_DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [63:0] exp);
    bus.nicEn = 1'b1;
    bus.nicEnWr = 1'b0;
    bus.addr = a;
    #1 chk(tag, bus.d_out, exp);
    tick();
    bus.nicEn = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] v);
    bus.nicEn = 1'b1;
    bus.nicEnWr = 1'b1;
    bus.addr = a;
    bus.d_in = v;
    tick();
    bus.nicEn = 1'b0;
    bus.nicEnWr = 1'b0;
  endtask

  logic [63:0] exp_full [4] = '{64'h8000000000000001, 64'h4000000000000001,
                                64'hC000000000000001, 64'h2000000000000001};
  logic [63:0] exp_aa   [4] = '{64'h0400000000000000, 64'h0C00000000000000,
                                64'h0200000000000000, 64'h5500000000000000};

  initial begin
    bus.addr = 2'b00;
    bus.d_in = '0;
    bus.nicEn = 1'b0;
    bus.nicEnWr = 1'b0;
    bus.net_si = 1'b0;
    bus.net_di = '0;
    bus.net_ro = 1'b0;
    bus.net_polarity = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("ri_in_reset", bus.net_ri, 0);
    chk("so_in_reset", bus.net_so, 0);
    reset = 1'b0;
    #1 chk("ri_idle", bus.net_ri, 1);
    chk("so_idle", bus.net_so, 0);
    chk("dout_idle", bus.d_out, 0);
    rd_chk("st01_idle", 2'b01, 0);
    rd_chk("st11_idle", 2'b11, 0);

    bus.net_si = 1'b1;
    bus.net_di = 64'h1;
    tick();
    bus.net_di = 64'h8000000000000000;
    tick();
    bus.net_si = 1'b0;
    rd_chk("st01_two", 2'b01, 64'h5);
    rd_chk("in_pop0", 2'b00, 64'h8000000000000000);
    rd_chk("st01_one", 2'b01, 64'h3);
    rd_chk("in_pop1", 2'b00, 64'h1);
    rd_chk("st01_empty", 2'b01, 64'h0);

    for (int i = 1; i <= 5; i++) wr(2'b10, 64'(i));
    rd_chk("peek_out", 2'b10, 64'h1);
    rd_chk("st11_drop", 2'b11, 64'h8000000000000009);
    rd_chk("st11_clr", 2'b11, 64'h9);

    bus.net_polarity = 1'b0;
    bus.net_ro = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("drain_so", bus.net_so, 1);
      chk("drain_do", bus.net_do, exp_full[i]);
      tick();
    end
    bus.net_ro = 1'b0;
    #1 chk("drained_so", bus.net_so, 0);
    chk("drained_do", bus.net_do, 0);

    wr(2'b10, 64'h10);
    wr(2'b10, 64'h20);
    wr(2'b10, 64'h30);
    wr(2'b10, 64'h40);
    bus.net_ro = 1'b1;
    bus.nicEn = 1'b1;
    bus.nicEnWr = 1'b1;
    bus.addr = 2'b10;
    bus.d_in = 64'hAA;
    #1 chk("full_pp_so", bus.net_so, 1);
    chk("full_pp_do", bus.net_do, 64'h0800000000000001);
    tick();
    bus.nicEn = 1'b0;
    bus.nicEnWr = 1'b0;
    bus.net_polarity = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("aa_so", bus.net_so, 1);
      chk("aa_do", bus.net_do, exp_aa[i]);
      tick();
    end
    bus.net_ro = 1'b0;
    rd_chk("st11_nodrop", 2'b11, 0);

    bus.net_si = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.net_di = 64'(i + 1);
      #1 chk("fill_ri", bus.net_ri, 1);
      tick();
    end
    #1 chk("full_ri", bus.net_ri, 0);
    bus.net_di = 64'hFF;
    tick();
    bus.net_si = 1'b0;
    rd_chk("st01_full", 2'b01, 64'h9);
    rd_chk("in_head_full", 2'b00, 64'h8000000000000000);
    #1 chk("ri_after_pop", bus.net_ri, 1);
    wr(2'b10, 64'h7);
    wr(2'b10, 64'h8);
    reset = 1'b1;
    bus.net_ro = 1'b1;
    #1 chk("rst_ri", bus.net_ri, 0);
    chk("rst_so", bus.net_so, 0);
    tick();
    reset = 1'b0;
    #1 chk("post_rst_ri", bus.net_ri, 1);
    chk("post_rst_so", bus.net_so, 0);
    chk("post_rst_dout", bus.d_out, 0);
    bus.net_ro = 1'b0;
    rd_chk("post_rst_st01", 2'b01, 0);
    rd_chk("post_rst_st11", 2'b11, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
